// File: rtl/is_pkg_uart_controller.sv
// Shared types and helpers for the UART controller.
// Line levels, TX state encoding and baud divisor math.
package is_pkg_uart_controller;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   localparam logic UART_IDLE  = 1'b1;
   localparam logic UART_START = 1'b0;

   // Integer divide; the remainder is dropped, so the line rate rounds up.
   function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/is_uart_baud_cnt.sv
// Restartable per-bit cycle counter for the UART transmitter.
// Pulses bit_done_o on the last cycle of every bit period.
module is_uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic bit_done_o
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign bit_done_o = en_i && (cnt_q == CNT_LAST);

   // Next count: clear wins, wrap at the end of a bit, else step.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (bit_done_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/is_uart_tx.sv
// UART transmitter: valid/ready byte in, framed serial line out.
// Start, DATA_W data bits LSB first, optional parity, 1 or 2 stops.
module is_uart_tx
   import is_pkg_uart_controller::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int DATA_W      = 8,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic              tx_busy_o,
   output logic              uart_data_tx_o
);

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
   localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic PAR_INV = (PARITY_ODD != 0);
   localparam bit HAS_PARITY = (PARITY_EN != 0);

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("is_uart_tx: CLKS_PER_BIT must be at least 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("is_uart_tx: STOP_BITS must be 1 or 2");
   end
   if (DATA_W < 5 || DATA_W > 9) begin : g_bad_dw
      $error("is_uart_tx: DATA_W must be in 5..9");
   end

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [3:0]        bit_idx_q, bit_idx_d;
   logic              parity_q, parity_d;
   logic              line_q, line_d;

   logic accept;
   logic bit_done;

   assign tx_ready_o     = (state_q == TX_IDLE);
   assign tx_busy_o      = ~tx_ready_o;
   assign uart_data_tx_o = line_q;
   assign accept         = tx_ready_o && tx_valid_i;

   is_uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (accept),
      .en_i      (tx_busy_o),
      .bit_done_o(bit_done)
   );

   // Frame sequencing; the line level for each bit is set at its first edge.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      parity_d  = parity_q;
      line_d    = line_q;
      unique case (state_q)
         TX_IDLE: begin
            line_d = UART_IDLE;
            if (tx_valid_i) begin
               state_d   = TX_START;
               shift_d   = tx_data_i;
               parity_d  = (^tx_data_i) ^ PAR_INV;
               bit_idx_d = '0;
               line_d    = UART_START;
            end
         end
         TX_START: begin
            if (bit_done) begin
               state_d   = TX_DATA;
               line_d    = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_idx_d = '0;
            end
         end
         TX_DATA: begin
            if (bit_done) begin
               if (bit_idx_q == LAST_DATA) begin
                  bit_idx_d = '0;
                  if (HAS_PARITY) begin
                     state_d = TX_PARITY;
                     line_d  = parity_q;
                  end else begin
                     state_d = TX_STOP;
                     line_d  = UART_IDLE;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  line_d    = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end
         end
         TX_PARITY: begin
            if (bit_done) begin
               state_d   = TX_STOP;
               line_d    = UART_IDLE;
               bit_idx_d = '0;
            end
         end
         TX_STOP: begin
            if (bit_done) begin
               if (bit_idx_q == LAST_STOP) begin
                  state_d = TX_IDLE;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
               line_d = UART_IDLE;
            end
         end
         default: begin
            state_d = TX_IDLE;
            line_d  = UART_IDLE;
         end
      endcase
   end

   // State, datapath and line registers; reset truncates any frame.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= TX_IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         parity_q  <= 1'b0;
         line_q    <= UART_IDLE;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         parity_q  <= parity_d;
         line_q    <= line_d;
      end
   end

endmodule

// File: tb/tb_is_uart_tx.sv
// Self-checking bench for is_uart_tx over four frame formats.
// Expected line is built from the frame bit list held CPB cycles each.
`timescale 1ns/1ps
module tb_is_uart_tx;

   localparam int CPB = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] valid;
   logic [7:0] din [4];
   wire  [3:0] line;
   wire  [3:0] rdy;
   wire  [3:0] bsy;

   int checks = 0;
   int errors = 0;

   logic exp_bits[$];
   logic obs_line[$];
   logic obs_rdy[$];
   logic obs_bsy[$];
   logic pre_line;
   logic pre_rdy;

   always #5 clk = ~clk;

   is_uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_W(8),
      .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
      .clk_i(clk), .rst_i(rst), .tx_data_i(din[0]), .tx_valid_i(valid[0]),
      .tx_ready_o(rdy[0]), .tx_busy_o(bsy[0]), .uart_data_tx_o(line[0]));

   is_uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_W(8),
      .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
      .clk_i(clk), .rst_i(rst), .tx_data_i(din[1]), .tx_valid_i(valid[1]),
      .tx_ready_o(rdy[1]), .tx_busy_o(bsy[1]), .uart_data_tx_o(line[1]));

   is_uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_W(8),
      .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
      .clk_i(clk), .rst_i(rst), .tx_data_i(din[2]), .tx_valid_i(valid[2]),
      .tx_ready_o(rdy[2]), .tx_busy_o(bsy[2]), .uart_data_tx_o(line[2]));

   is_uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_W(8),
      .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
      .clk_i(clk), .rst_i(rst), .tx_data_i(din[3]), .tx_valid_i(valid[3]),
      .tx_ready_o(rdy[3]), .tx_busy_o(bsy[3]), .uart_data_tx_o(line[3]));

   function automatic int cfg_pen(input int i);
      return (i == 1 || i == 2) ? 1 : 0;
   endfunction

   function automatic int cfg_odd(input int i);
      return (i == 2) ? 1 : 0;
   endfunction

   function automatic int cfg_stp(input int i);
      return (i == 3) ? 2 : 1;
   endfunction

   // Reference frame: list of line levels, one entry per bit.
   function automatic void build_frame(input logic [7:0] b, input int i);
      int ones;
      ones = 0;
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) begin
         exp_bits.push_back(b[j]);
         ones += int'(b[j]);
      end
      if (cfg_pen(i) != 0) exp_bits.push_back(1'((ones % 2) ^ cfg_odd(i)));
      for (int j = 0; j < cfg_stp(i); j++) exp_bits.push_back(1'b1);
   endfunction

   function automatic logic exp_line(input int k);
      if (k / CPB < exp_bits.size()) return exp_bits[k / CPB];
      return 1'b1;
   endfunction

   // Offer byte b once on instance i and record ncyc post-accept samples.
   task automatic run_frame(input int i, input logic [7:0] b, input int ncyc);
      obs_line.delete();
      obs_rdy.delete();
      obs_bsy.delete();
      pre_line = line[i];
      pre_rdy = rdy[i];
      din[i] = b;
      valid[i] = 1'b1;
      @(posedge clk); #1;
      valid[i] = 1'b0;
      din[i] = 8'($urandom);
      for (int k = 0; k < ncyc; k++) begin
         obs_line.push_back(line[i]);
         obs_rdy.push_back(rdy[i]);
         obs_bsy.push_back(bsy[i]);
         if (k == ncyc / 2) din[i] = 8'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      int bad;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (line[i] !== 1'b1) begin
            errors++;
            $display("FAIL reset_line[%0d]: got %b want 1", i, line[i]);
         end
         checks++;
         if (rdy[i] !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready[%0d]: got %b want 1", i, rdy[i]);
         end
         checks++;
         if (bsy[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy[%0d]: got %b want 0", i, bsy[i]);
         end
      end
      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (line !== 4'hF || rdy !== 4'hF) bad++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL idle_no_valid: %0d bad cycles want 0", bad);
      end
   endtask

   task automatic test_8n1;
      logic mid [10];
      int lows;
      mid = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      run_frame(0, 8'hA5, 105);
      checks++;
      if (pre_line !== 1'b1 || obs_line[0] !== 1'b0) begin
         errors++;
         $display("FAIL a5_fall: before=%b after=%b want 1 then 0",
                  pre_line, obs_line[0]);
      end
      for (int j = 0; j < 10; j++) begin
         checks++;
         if (obs_line[j * CPB + 5] !== mid[j]) begin
            errors++;
            $display("FAIL a5_bit%0d: got %b want %b", j,
                     obs_line[j * CPB + 5], mid[j]);
         end
      end
      lows = 0;
      foreach (obs_rdy[k]) if (obs_rdy[k] === 1'b0) lows++;
      checks++;
      if (lows != 100 || obs_rdy[100] !== 1'b1) begin
         errors++;
         $display("FAIL a5_ready_low: got %0d clks (rise=%b) want 100",
                  lows, obs_rdy[100]);
      end
   endtask

   task automatic test_parity;
      logic [7:0] bytes [3];
      int inst [3];
      logic want [3];
      int lows;
      bytes = '{8'h07, 8'h03, 8'h03};
      inst = '{1, 1, 2};
      want = '{1'b1, 1'b0, 1'b1};
      for (int t = 0; t < 3; t++) begin
         run_frame(inst[t], bytes[t], 115);
         checks++;
         if (obs_line[9 * CPB + 5] !== want[t]) begin
            errors++;
            $display("FAIL parity_%0d_%02h: got %b want %b", inst[t],
                     bytes[t], obs_line[9 * CPB + 5], want[t]);
         end
         lows = 0;
         foreach (obs_rdy[k]) if (obs_rdy[k] === 1'b0) lows++;
         checks++;
         if (lows != 110) begin
            errors++;
            $display("FAIL parity_frame_len_%0d: got %0d want 110", t, lows);
         end
      end
   endtask

   task automatic test_stop2;
      int highs;
      int lows;
      run_frame(3, 8'h3C, 115);
      highs = 0;
      for (int k = 90; k < 110; k++) if (obs_line[k] === 1'b1) highs++;
      checks++;
      if (highs != 20 || obs_line[89] !== 1'b0) begin
         errors++;
         $display("FAIL stop2_level: high=%0d bit7=%b want 20 and 0",
                  highs, obs_line[89]);
      end
      lows = 0;
      foreach (obs_rdy[k]) if (obs_rdy[k] === 1'b0) lows++;
      checks++;
      if (lows != 110 || obs_rdy[110] !== 1'b1) begin
         errors++;
         $display("FAIL stop2_ready: low=%0d rise=%b want 110 and 1",
                  lows, obs_rdy[110]);
      end
   endtask

   task automatic test_back_to_back;
      logic f1[$];
      logic f2[$];
      logic e;
      logic er;
      int bad_l;
      int bad_r;
      int first;
      int run;
      logic [7:0] d1;
      logic [7:0] d2;
      build_frame(8'h55, 0);
      f1 = exp_bits;
      build_frame(8'hAA, 0);
      f2 = exp_bits;
      obs_line.delete();
      obs_rdy.delete();
      din[0] = 8'h55;
      valid[0] = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 206; k++) begin
         if (k == 0) din[0] = 8'($urandom);
         if (k == 50) din[0] = 8'hAA;
         obs_line.push_back(line[0]);
         obs_rdy.push_back(rdy[0]);
         if (k == 101) valid[0] = 1'b0;
         @(posedge clk); #1;
      end
      bad_l = 0;
      bad_r = 0;
      first = -1;
      for (int k = 0; k < 206; k++) begin
         if (k < 100) begin
            e = f1[k / CPB];
            er = 1'b0;
         end else if (k == 100) begin
            e = 1'b1;
            er = 1'b1;
         end else if (k < 201) begin
            e = f2[(k - 101) / CPB];
            er = 1'b0;
         end else begin
            e = 1'b1;
            er = 1'b1;
         end
         if (obs_line[k] !== e) begin
            bad_l++;
            if (first < 0) first = k;
         end
         if (obs_rdy[k] !== er) bad_r++;
      end
      checks++;
      if (bad_l != 0) begin
         errors++;
         $display("FAIL b2b_line: %0d bad cycles, first at %0d got %b",
                  bad_l, first, obs_line[first]);
      end
      checks++;
      if (bad_r != 0) begin
         errors++;
         $display("FAIL b2b_ready: %0d bad cycles want 0", bad_r);
      end
      run = 0;
      for (int k = 90; k < 206 && obs_line[k] === 1'b1; k++) run++;
      checks++;
      if (run != 11) begin
         errors++;
         $display("FAIL b2b_gap: got %0d high clks want 11", run);
      end
      for (int j = 0; j < 8; j++) begin
         d1[j] = obs_line[15 + j * CPB];
         d2[j] = obs_line[101 + 15 + j * CPB];
      end
      checks++;
      if (d1 !== 8'h55) begin
         errors++;
         $display("FAIL b2b_first_byte: got %02h want 55", d1);
      end
      checks++;
      if (d2 !== 8'hAA) begin
         errors++;
         $display("FAIL b2b_second_byte: got %02h want aa", d2);
      end
   endtask

   task automatic test_reset_mid;
      int bad;
      int first;
      din[0] = 8'h00;
      valid[0] = 1'b1;
      @(posedge clk); #1;
      valid[0] = 1'b0;
      repeat (45) begin
         @(posedge clk); #1;
      end
      checks++;
      if (line[0] !== 1'b0 || rdy[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_bit3_state: line=%b ready=%b want 0 0",
                  line[0], rdy[0]);
      end
      rst = 1'b1;
      valid[0] = 1'b1;
      din[0] = 8'hFF;
      @(posedge clk); #1;
      checks++;
      if (line[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: line=%b ready=%b busy=%b want 1 1 0",
                  line[0], rdy[0], bsy[0]);
      end
      rst = 1'b0;
      valid[0] = 1'b0;
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         if (line[0] !== 1'b1 || rdy[0] !== 1'b1) bad++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_valid_in_reset: %0d busy cycles want 0", bad);
      end
      build_frame(8'hFF, 0);
      run_frame(0, 8'hFF, 105);
      bad = 0;
      first = -1;
      for (int k = 0; k < 105; k++) begin
         if (obs_line[k] !== exp_line(k)) begin
            bad++;
            if (first < 0) first = k;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL after_reset_ff: %0d bad cycles, first %0d got %b",
                  bad, first, obs_line[first]);
      end
   endtask

   task automatic test_random;
      int i;
      int n;
      int bad_l;
      int bad_r;
      int bad_b;
      logic [7:0] b;
      logic er;
      for (int t = 0; t < 8; t++) begin
         i = int'($urandom_range(0, 3));
         b = 8'($urandom);
         build_frame(b, i);
         n = exp_bits.size() * CPB;
         run_frame(i, b, n + 3);
         bad_l = 0;
         bad_r = 0;
         bad_b = 0;
         for (int k = 0; k < n + 3; k++) begin
            er = (k < n) ? 1'b0 : 1'b1;
            if (obs_line[k] !== exp_line(k)) bad_l++;
            if (obs_rdy[k] !== er) bad_r++;
            if (obs_bsy[k] !== ~er) bad_b++;
         end
         checks++;
         if (bad_l != 0) begin
            errors++;
            $display("FAIL rand_line inst%0d byte %02h: %0d bad cycles want 0",
                     i, b, bad_l);
         end
         checks++;
         if (bad_r != 0 || pre_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rand_ready inst%0d byte %02h: %0d bad, pre=%b",
                     i, b, bad_r, pre_rdy);
         end
         checks++;
         if (bad_b != 0) begin
            errors++;
            $display("FAIL rand_busy inst%0d byte %02h: %0d bad cycles want 0",
                     i, b, bad_b);
         end
      end
   endtask

   initial begin
      valid = 4'h0;
      for (int i = 0; i < 4; i++) din[i] = 8'h00;
      test_reset;
      test_8n1;
      test_parity;
      test_stop2;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
